// File: rtl/game_master_fsm.sv
// Game sequencer for the target/torpedo shooter: reloads and enables sprites,
// detects win/lose, and times the end-of-game display for the pixel mixer.
module game_master_fsm #(
    parameter int unsigned END_FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic launch_key,
    input  logic end_of_frame,
    input  logic collision,
    input  logic target_out_of_screen,
    input  logic torpedo_out_of_screen,
    output logic sprite_target_write_xy,
    output logic sprite_torpedo_write_xy,
    output logic sprite_target_enable_update,
    output logic sprite_torpedo_enable_update,
    output logic end_of_game_timer_running,
    output logic game_won
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_AIM   = 2'd1,
        ST_SHOOT = 2'd2,
        ST_END   = 2'd3
    } state_t;

    localparam logic [7:0] LAST_FRAME = 8'(END_FRAMES - 1);

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic       r_game_won;
    logic       r_target_write_xy;
    logic       r_torpedo_write_xy;
    logic       r_target_enable;
    logic       r_torpedo_enable;
    logic       r_timer_running;

    state_t     w_next;
    logic       w_won_next;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_won_next = r_game_won;
        unique case (r_state)
            ST_START: w_next = ST_AIM;
            ST_AIM: begin
                if (target_out_of_screen) begin
                    w_next     = ST_END;
                    w_won_next = 1'b0;
                end else if (launch_key) begin
                    w_next = ST_SHOOT;
                end
            end
            ST_SHOOT: begin
                // A hit outranks any sprite leaving the screen in the same cycle.
                if (collision) begin
                    w_next     = ST_END;
                    w_won_next = 1'b1;
                end else if (target_out_of_screen || torpedo_out_of_screen) begin
                    w_next     = ST_END;
                    w_won_next = 1'b0;
                end
            end
            ST_END: begin
                if (end_of_frame && r_frame_cnt == LAST_FRAME) begin
                    w_next = ST_START;
                end
            end
            default: w_next = ST_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_START;
            r_frame_cnt        <= 8'd0;
            r_game_won         <= 1'b0;
            r_target_write_xy  <= 1'b1;
            r_torpedo_write_xy <= 1'b1;
            r_target_enable    <= 1'b0;
            r_torpedo_enable   <= 1'b0;
            r_timer_running    <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next == ST_START) begin
                r_frame_cnt <= 8'd0;
                r_game_won  <= 1'b0;
            end else begin
                if (r_state == ST_END && end_of_frame) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                if (r_state != ST_END && w_next == ST_END) begin
                    r_game_won <= w_won_next;
                end
            end

            // Outputs are registered from the next state so they track r_state exactly.
            r_target_write_xy  <= (w_next == ST_START);
            r_torpedo_write_xy <= (w_next == ST_START);
            r_target_enable    <= (w_next == ST_AIM) || (w_next == ST_SHOOT);
            r_torpedo_enable   <= (w_next == ST_SHOOT);
            r_timer_running    <= (w_next == ST_END);
        end
    end

    assign sprite_target_write_xy       = r_target_write_xy;
    assign sprite_torpedo_write_xy      = r_torpedo_write_xy;
    assign sprite_target_enable_update  = r_target_enable;
    assign sprite_torpedo_enable_update = r_torpedo_enable;
    assign end_of_game_timer_running    = r_timer_running;
    assign game_won                     = r_game_won;

endmodule

// File: tb/tb_game_master_fsm.sv
// Scoreboard bench for game_master_fsm: directed game scenarios plus random
// stimulus, checked against a behavioural game model.
module tb_game_master_fsm;

    localparam int unsigned END_FRAMES = 3;

    logic clk = 1'b0;
    logic reset;
    logic launch_key, end_of_frame, collision, target_out_of_screen, torpedo_out_of_screen;
    logic sprite_target_write_xy, sprite_torpedo_write_xy;
    logic sprite_target_enable_update, sprite_torpedo_enable_update;
    logic end_of_game_timer_running, game_won;

    game_master_fsm #(.END_FRAMES(END_FRAMES)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .launch_key                   (launch_key),
        .end_of_frame                 (end_of_frame),
        .collision                    (collision),
        .target_out_of_screen         (target_out_of_screen),
        .torpedo_out_of_screen        (torpedo_out_of_screen),
        .sprite_target_write_xy       (sprite_target_write_xy),
        .sprite_torpedo_write_xy      (sprite_torpedo_write_xy),
        .sprite_target_enable_update  (sprite_target_enable_update),
        .sprite_torpedo_enable_update (sprite_torpedo_enable_update),
        .end_of_game_timer_running    (end_of_game_timer_running),
        .game_won                     (game_won)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {tgt_wxy, trp_wxy, tgt_en, trp_en, running, won}
    logic [5:0] exp_q[$];

    // Behavioural model: what the player is doing, and how many frames of the end screen have elapsed.
    string m_mode;
    int    m_frames;
    bit    m_won;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [5:0] dut_outputs();
        return {sprite_target_write_xy, sprite_torpedo_write_xy,
                sprite_target_enable_update, sprite_torpedo_enable_update,
                end_of_game_timer_running, game_won};
    endfunction

    function automatic logic [5:0] model_outputs();
        case (m_mode)
            "reload": return {4'b1100, 1'b0, m_won};
            "aim":    return {4'b0010, 1'b0, m_won};
            "flight": return {4'b0011, 1'b0, m_won};
            default:  return {4'b0000, 1'b1, m_won};
        endcase
    endfunction

    task automatic model_reset();
        m_mode   = "reload";
        m_frames = 0;
        m_won    = 1'b0;
    endtask

    task automatic model_step(input bit lk, input bit eof, input bit col, input bit tout, input bit pout);
        if (m_mode == "reload") begin
            m_mode = "aim";
        end else if (m_mode == "aim") begin
            if (tout) begin
                m_mode = "over"; m_won = 1'b0; m_frames = 0;
            end else if (lk) begin
                m_mode = "flight";
            end
        end else if (m_mode == "flight") begin
            if (col) begin
                m_mode = "over"; m_won = 1'b1; m_frames = 0;
            end else if (tout || pout) begin
                m_mode = "over"; m_won = 1'b0; m_frames = 0;
            end
        end else begin
            if (eof) begin
                m_frames++;
                if (m_frames == END_FRAMES) begin
                    m_mode = "reload"; m_won = 1'b0;
                end
            end
        end
    endtask

    // Called at a negedge: apply inputs, predict the post-edge outputs, advance to the next negedge.
    task automatic drive(input bit lk, input bit eof, input bit col, input bit tout, input bit pout);
        launch_key            = lk;
        end_of_frame          = eof;
        collision             = col;
        target_out_of_screen  = tout;
        torpedo_out_of_screen = pout;
        model_step(lk, eof, col, tout, pout);
        exp_q.push_back(model_outputs());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic end_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, 0, 0);
            idle(gap);
        end
    endtask

    task automatic drain();
        int budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses never consumed", exp_q.size());
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", dut_outputs(), e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        launch_key = 0; end_of_frame = 0; collision = 0;
        target_out_of_screen = 0; torpedo_out_of_screen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_values", dut_outputs(), 6'b110000);
        @(negedge clk);
        reset = 1'b0;
        #1 check("start_after_release", dut_outputs(), 6'b110000);

        // Idle in AIM, fire, hit.
        idle(100);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        end_pulses(3, 9);
        idle(3);

        // Collision and torpedo exit together: the hit wins.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        end_pulses(3, 0);
        idle(2);

        // Torpedo exit only: a loss.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        end_pulses(3, 2);
        idle(2);

        // Target leaves while the key is pressed in AIM: a loss, not a shot.
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        end_pulses(3, 1);

        // Held key re-fires one cycle after the reload.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        end_pulses(2, 1);

        // Two frames into the end screen: asynchronous reset between edges.
        drain();
        check("end_active_before_reset", dut_outputs(), 6'b000011);
        #2 reset = 1'b1;
        #1 check("async_reset_mid_end", dut_outputs(), 6'b110000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Next game end needs the full END_FRAMES again.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        end_pulses(3, 1);
        idle(2);

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(15) == 0, $urandom_range(15) == 0);
        end
        idle(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
